// File: rtl/lvds_rx_align_pkg.sv
// Shared types and constants for the LVDS receive word aligner.
// Pure declarations: no logic, no latency.
// Not applicable for backpressure.
package lvds_rx_align_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } align_state_t;

    localparam logic [7:0] DEF_TRAIN_PATTERN = 8'hF0;

    // Verify and sweep counters cover the 1..15 parameter range.
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/lvds_rx_barrel.sv
// Window select: picks a DATA_W-bit candidate from {din, din_prev} at bit offset off.
// Combinational, zero latency.
// No backpressure; also used by the TX-side loopback checker.
module lvds_rx_barrel #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]         din,
    input  logic [DATA_W-1:0]         din_prev,
    input  logic [$clog2(DATA_W)-1:0] off,
    output logic [DATA_W-1:0]         cand
);

    localparam int SEL_W = $clog2(2 * DATA_W);

    logic [2*DATA_W-1:0] win;
    logic [SEL_W-1:0]    sel;

    assign win  = {din, din_prev};
    // Widen the offset so the part-select index covers the whole window.
    assign sel  = SEL_W'(off);
    assign cand = win[sel +: DATA_W];

endmodule

// File: rtl/lvds_rx_word_aligner.sv
// Hunts the training pattern across bit offsets, verifies lock, then emits aligned words.
// dout/dout_valid registered, one cycle after din/din_valid; no backpressure (din_valid only).
// Define LVDS_RX_ALIGN_STATS_EN to add relock_cnt and slip_cnt outputs.
module lvds_rx_word_aligner
    import lvds_rx_align_pkg::*;
#(
    parameter int                 DATA_W        = 8,
    parameter logic [DATA_W-1:0]  TRAIN_PATTERN = DATA_W'(DEF_TRAIN_PATTERN),
    parameter int                 MATCH_CNT     = 4,
    parameter int                 MAX_SWEEPS    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pll_locked,
    input  logic [DATA_W-1:0]         din,
    input  logic                      din_valid,
    output logic [DATA_W-1:0]         dout,
    output logic                      dout_valid,
    output logic                      aligned,
    output logic [$clog2(DATA_W)-1:0] bit_offset,
    output logic                      align_err
`ifdef LVDS_RX_ALIGN_STATS_EN
    ,
    output logic [STAT_W-1:0]         relock_cnt,
    output logic [STAT_W-1:0]         slip_cnt
`endif
);

    localparam int OFF_W = $clog2(DATA_W);

    align_state_t      state_q, state_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              primed_q, primed_d;
    logic [CNT_W-1:0]  vcnt_q, vcnt_d;
    logic [CNT_W-1:0]  sweep_q, sweep_d;
    logic              align_err_q, align_err_d;
    logic [DATA_W-1:0] din_prev_q, din_prev_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              aligned_q, aligned_d;

    logic [DATA_W-1:0] cand;
    logic              match;
    logic              slip;
    logic              wrap;
    logic [OFF_W-1:0]  off_inc;
    logic [CNT_W-1:0]  vcnt_inc;
    logic [CNT_W-1:0]  sweep_inc;

    lvds_rx_barrel #(
        .DATA_W (DATA_W)
    ) u_barrel (
        .din      (din),
        .din_prev (din_prev_q),
        .off      (off_q),
        .cand     (cand)
    );

    assign match     = (cand == TRAIN_PATTERN);
    assign wrap      = (off_q == OFF_W'(DATA_W - 1));
    assign off_inc   = wrap ? '0 : off_q + OFF_W'(1);
    assign vcnt_inc  = vcnt_q + CNT_W'(1);
    assign sweep_inc = (sweep_q == CNT_W'(MAX_SWEEPS)) ? sweep_q : sweep_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        primed_d     = primed_q;
        vcnt_d       = vcnt_q;
        sweep_d      = sweep_q;
        align_err_d  = align_err_q;
        din_prev_d   = din_valid ? din : din_prev_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        slip         = 1'b0;

        // Lock loss outranks any match/mismatch seen in the same cycle.
        if (!pll_locked) begin
            state_d  = ST_IDLE;
            off_d    = '0;
            primed_d = 1'b0;
            vcnt_d   = '0;
            sweep_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_HUNT;
                ST_HUNT: begin
                    if (din_valid) begin
                        if (!primed_q) begin
                            primed_d = 1'b1;
                        end else if (match) begin
                            state_d = ST_VERIFY;
                            vcnt_d  = '0;
                        end else begin
                            slip = 1'b1;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (din_valid) begin
                        if (match) begin
                            vcnt_d = vcnt_inc;
                            if (vcnt_inc == CNT_W'(MATCH_CNT)) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            state_d = ST_HUNT;
                            slip    = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (din_valid) begin
                        dout_d       = cand;
                        dout_valid_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (slip) begin
                off_d = off_inc;
                if (wrap) begin
                    sweep_d = sweep_inc;
                    if (sweep_inc == CNT_W'(MAX_SWEEPS)) begin
                        align_err_d = 1'b1;
                    end
                end
            end
        end

        aligned_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            off_q        <= '0;
            primed_q     <= 1'b0;
            vcnt_q       <= '0;
            sweep_q      <= '0;
            align_err_q  <= 1'b0;
            din_prev_q   <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            aligned_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            primed_q     <= primed_d;
            vcnt_q       <= vcnt_d;
            sweep_q      <= sweep_d;
            align_err_q  <= align_err_d;
            din_prev_q   <= din_prev_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            aligned_q    <= aligned_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign aligned    = aligned_q;
    assign bit_offset = off_q;
    assign align_err  = align_err_q;

`ifdef LVDS_RX_ALIGN_STATS_EN
    logic [STAT_W-1:0] relock_cnt_q, relock_cnt_d;
    logic [STAT_W-1:0] slip_cnt_q, slip_cnt_d;
    logic              locked_once_q, locked_once_d;
    logic              lock_entry;

    always_comb begin
        lock_entry    = (state_d == ST_LOCKED) && (state_q != ST_LOCKED);
        locked_once_d = locked_once_q | lock_entry;
        relock_cnt_d  = relock_cnt_q;
        slip_cnt_d    = slip_cnt_q;
        // The very first lock is not a relock.
        if (lock_entry && locked_once_q && (relock_cnt_q != '1)) begin
            relock_cnt_d = relock_cnt_q + STAT_W'(1);
        end
        if (slip && (slip_cnt_q != '1)) begin
            slip_cnt_d = slip_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            relock_cnt_q  <= '0;
            slip_cnt_q    <= '0;
            locked_once_q <= 1'b0;
        end else begin
            relock_cnt_q  <= relock_cnt_d;
            slip_cnt_q    <= slip_cnt_d;
            locked_once_q <= locked_once_d;
        end
    end

    assign relock_cnt = relock_cnt_q;
    assign slip_cnt   = slip_cnt_q;
`else
`endif

endmodule
